// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, widths and address-window decode for the
// interconnect and its register-bank slaves.
package axi_lite_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  // One paired write: address, data and byte strobes as seen at commit.
  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_STRB_WIDTH-1:0] strb;
  } axi_lite_bus_t;

  // True when addr falls in [base, base + 4*nregs); subtracting first keeps
  // the upper bound from overflowing near the top of the address space.
  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                    input logic [AXI_ADDR_WIDTH-1:0] base,
                                    input int unsigned nregs);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - base;
    return (addr >= base) && (off < AXI_ADDR_WIDTH'(nregs * 4));
  endfunction

endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite slave-side bus bundle plus FSM state debug taps.
// Handshake rule: a transfer happens on a rising aclk where valid and ready are
// both 1; a source holds valid and its payload stable until that edge.
interface axi_lite_slave_regs_if
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  w_state_t              w_state_dbg;
  r_state_t              r_state_dbg;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    input  w_state_dbg, r_state_dbg
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output w_state_dbg, r_state_dbg
  );

endinterface

// File: rtl/axi_lite_wr_collector.sv
// Captures AW and W independently, in either order, and emits a one-cycle
// commit with the paired address/data/strobes once both are available.
module axi_lite_wr_collector
  import axi_lite_pkg::*;
(
  input  logic                      aclk,
  input  logic                      areset_n,
  input  logic                      idle,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [AXI_DATA_WIDTH-1:0] wdata,
  input  logic [AXI_STRB_WIDTH-1:0] wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic                      commit,
  output axi_lite_bus_t             wr
);

  logic                      aw_held;
  logic                      w_held;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [AXI_STRB_WIDTH-1:0] strb_q;
  logic                      aw_hs;
  logic                      w_hs;

  assign awready = areset_n && idle && !aw_held;
  assign wready  = areset_n && idle && !w_held;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Commit on the edge where the later half arrives, or both arrive together.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);

  always_comb begin
    wr.addr = aw_held ? addr_q : awaddr;
    wr.data = w_held  ? data_q : wdata;
    wr.strb = w_held  ? strb_q : wstrb;
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        addr_q  <= awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        data_q <= wdata;
        strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register bank of NUM_REGS words at BASE_ADDR with independent
// write and read paths; out-of-window accesses answer SLVERR.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int                      ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int                      DATA_WIDTH = AXI_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 32'h0,
  parameter int                      NUM_REGS   = 4
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  axi_lite_slave_regs_if.slave  bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  function automatic logic [IDX_W-1:0] reg_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  w_state_t      w_state, w_next;
  r_state_t      r_state, r_next;
  logic          commit;
  axi_lite_bus_t wr;
  logic          wr_ok;
  logic [IDX_W-1:0] wr_idx;
  resp_t         bresp_q;
  logic          ar_hs;
  logic          rd_ok;
  logic [IDX_W-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_t         rresp_q;

  axi_lite_wr_collector u_wr_collector (
    .aclk     (aclk),
    .areset_n (areset_n),
    .idle     (w_state == W_IDLE),
    .awaddr   (bus.awaddr),
    .awvalid  (bus.awvalid),
    .awready  (bus.awready),
    .wdata    (bus.wdata),
    .wstrb    (bus.wstrb),
    .wvalid   (bus.wvalid),
    .wready   (bus.wready),
    .commit   (commit),
    .wr       (wr)
  );

  assign wr_ok  = in_range(wr.addr, BASE_ADDR, NUM_REGS);
  assign wr_idx = reg_index(wr.addr);
  assign rd_ok  = in_range(bus.araddr, BASE_ADDR, NUM_REGS);
  assign rd_idx = reg_index(bus.araddr);

  assign bus.bvalid      = (w_state == W_RESP);
  assign bus.bresp       = bresp_q;
  assign bus.arready     = areset_n && (r_state == R_IDLE);
  assign bus.rvalid      = (r_state == R_RESP);
  assign bus.rdata       = rdata_q;
  assign bus.rresp       = rresp_q;
  assign bus.w_state_dbg = w_state;
  assign bus.r_state_dbg = r_state;
  assign ar_hs           = bus.arvalid && bus.arready;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (bus.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (bus.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Register writes and read sampling share an edge: a read handshaking with a
  // commit to the same word captures the pre-write value.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bresp_q <= OKAY;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      if (commit) begin
        bresp_q <= wr_ok ? OKAY : SLVERR;
        if (wr_ok) begin
          for (int k = 0; k < STRB_WIDTH; k++)
            if (wr.strb[k]) regs[wr_idx][8*k +: 8] <= wr.data[8*k +: 8];
        end
      end
      if (ar_hs) begin
        rdata_q <= rd_ok ? regs[rd_idx] : '0;
        rresp_q <= rd_ok ? OKAY : SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scenario bench for axi_lite_slave_regs with a word-array reference model and
// randomized mixed traffic.
module tb_axi_lite_slave_regs;
  import axi_lite_pkg::*;

  localparam logic [31:0] BASE  = 32'h10;
  localparam int          NREGS = 4;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_mem [NREGS];
  logic [31:0] exp_q [$];

  axi_lite_slave_regs_if bus ();

  axi_lite_slave_regs #(.BASE_ADDR(BASE), .NUM_REGS(NREGS)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  always #5 aclk = ~aclk;

  // ---------------- reference model ----------------
  function automatic bit model_ok(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4 * NREGS);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (model_ok(a)) model_mem[model_idx(a)] = model_merge(model_mem[model_idx(a)], d, s);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NREGS; i++) model_mem[i] = 32'h0;
  endfunction

  // ---------------- drivers ----------------
  task automatic bus_idle();
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
  endtask

  // Issues AW after aw_dly cycles and W after w_dly cycles, then holds bready low
  // for 'hold' cycles once bvalid appears. Returns when B is consumed.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int hold,
                          output logic [1:0] resp, output int lat, output bit early,
                          output bit stable_ok, output bit timeout);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    cyc = 0; aw_done = 0; w_done = 0; early = 0; stable_ok = 1; timeout = 0; lat = 0; resp = 2'bxx;
    @(negedge aclk);
    while (!(aw_done && w_done)) begin
      if (bus.bvalid) early = 1;
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge aclk);
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      cyc++;
      if (cyc > 50) begin timeout = 1; break; end
      @(negedge aclk);
    end
    if (timeout) begin @(negedge aclk); bus_idle(); return; end
    @(negedge aclk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    lat = 1;
    while (!bus.bvalid && lat < 20) begin @(negedge aclk); lat++; end
    if (!bus.bvalid) begin timeout = 1; return; end
    resp = bus.bresp;
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      if (!bus.bvalid || bus.bresp !== resp || bus.awready || bus.wready) stable_ok = 0;
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    if (bus.bvalid) stable_ok = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat,
                         output bit stable_ok, output bit timeout);
    int cyc;
    bit hs;
    cyc = 0; hs = 0; stable_ok = 1; timeout = 0; lat = 0; data = 'x; resp = 2'bxx;
    @(negedge aclk);
    while (!hs) begin
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      hs = bus.arready;
      @(posedge aclk);
      cyc++;
      if (cyc > 50) begin timeout = 1; break; end
      @(negedge aclk);
    end
    if (timeout) begin @(negedge aclk); bus.arvalid = 1'b0; return; end
    bus.arvalid = 1'b0;
    lat = 1;
    while (!bus.rvalid && lat < 20) begin @(negedge aclk); lat++; end
    if (!bus.rvalid) begin timeout = 1; return; end
    data = bus.rdata;
    resp = bus.rresp;
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      if (!bus.rvalid || bus.rdata !== data || bus.rresp !== resp || bus.arready) stable_ok = 0;
    end
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0;
    if (bus.rvalid) stable_ok = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat; bit st, to;
    bus_idle();
    areset_n = 1'b0;
    repeat (3) @(negedge aclk);
    tests_run++;
    if (bus.awready !== 1'b0 || bus.wready !== 1'b0 || bus.arready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_low: aw/w/ar ready=%b%b%b required 000", bus.awready, bus.wready, bus.arready);
    end
    tests_run++;
    if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || bus.bresp !== 2'b00 || bus.rresp !== 2'b00 || bus.rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h required all 0",
               bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata);
    end
    areset_n = 1'b1;
    model_clear();
    @(negedge aclk);
    tests_run++;
    if (bus.awready !== 1'b1 || bus.wready !== 1'b1 || bus.arready !== 1'b1 ||
        bus.w_state_dbg !== W_IDLE || bus.r_state_dbg !== R_IDLE) begin
      tests_failed++;
      $display("FAIL reset_release_idle: aw/w/ar ready=%b%b%b wst=%0d rst=%0d required 111 idle",
               bus.awready, bus.wready, bus.arready, bus.w_state_dbg, bus.r_state_dbg);
    end
    do_read(BASE + 32'hC, 0, d, r, lat, st, to);
    tests_run++;
    if (to || d !== 32'h0 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_reg3_zero: rdata=%h rresp=%b timeout=%0d required 00000000 00", d, r, to);
    end
  endtask

  task automatic test_same_cycle_aw_w();
    logic [31:0] d; logic [1:0] r; int lat; bit early, st, to;
    do_write(BASE + 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, lat, early, st, to);
    model_write(BASE + 32'h4, 32'hDEADBEEF, 4'hF);
    tests_run++;
    if (to || r !== 2'b00 || lat != 1) begin
      tests_failed++;
      $display("FAIL same_cycle_write: bresp=%b latency=%0d timeout=%0d required 00 1 0", r, lat, to);
    end
    do_read(BASE + 32'h4, 0, d, r, lat, st, to);
    tests_run++;
    if (to || d !== 32'hDEADBEEF || r !== 2'b00 || lat != 1) begin
      tests_failed++;
      $display("FAIL read_deadbeef: rdata=%h rresp=%b latency=%0d required deadbeef 00 1", d, r, lat);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; int lat; bit early, st, to;
    do_write(BASE + 32'h8, 32'h11223344, 4'hF, 3, 0, 0, r, lat, early, st, to);
    model_write(BASE + 32'h8, 32'h11223344, 4'hF);
    tests_run++;
    if (to || early || r !== 2'b00 || lat != 1) begin
      tests_failed++;
      $display("FAIL w_first_write: early_bvalid=%0d bresp=%b latency=%0d required 0 00 1", early, r, lat);
    end
    do_read(BASE + 32'h8, 0, d, r, lat, st, to);
    tests_run++;
    if (to || d !== 32'h11223344 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL w_first_read: rdata=%h rresp=%b required 11223344 00", d, r);
    end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] d; logic [1:0] r; int lat; bit early, st, to;
    do_write(BASE + 32'h8, 32'hAABBCCDD, 4'b0101, 0, 1, 0, r, lat, early, st, to);
    model_write(BASE + 32'h8, 32'hAABBCCDD, 4'b0101);
    do_read(BASE + 32'h8, 0, d, r, lat, st, to);
    tests_run++;
    if (to || d !== 32'h11BB33DD || d !== model_mem[2]) begin
      tests_failed++;
      $display("FAIL partial_strobe: rdata=%h required 11bb33dd", d);
    end
    do_write(BASE + 32'h8, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, r, lat, early, st, to);
    do_read(BASE + 32'h8, 0, d, r, lat, st, to);
    tests_run++;
    if (to || d !== 32'h11BB33DD || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL zero_strobe: rdata=%h rresp=%b required 11bb33dd 00", d, r);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat; bit early, st, to;
    do_write(32'h20, 32'hCAFEF00D, 4'hF, 0, 0, 0, r, lat, early, st, to);
    tests_run++;
    if (to || r !== 2'b10) begin
      tests_failed++;
      $display("FAIL oor_write_bresp: bresp=%b required 10", r);
    end
    do_read(32'h0C, 0, d, r, lat, st, to);
    tests_run++;
    if (to || r !== 2'b10 || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL oor_read_below: rdata=%h rresp=%b required 00000000 10", d, r);
    end
    do_read(32'h20, 0, d, r, lat, st, to);
    tests_run++;
    if (to || r !== 2'b10 || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL oor_read_above: rdata=%h rresp=%b required 00000000 10", d, r);
    end
    for (int i = 0; i < NREGS; i++) begin
      do_read(BASE + 32'(4 * i), 0, d, r, lat, st, to);
      tests_run++;
      if (to || r !== 2'b00 || d !== model_mem[i]) begin
        tests_failed++;
        $display("FAIL oor_regs_unchanged[%0d]: rdata=%h rresp=%b required %h 00", i, d, r, model_mem[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] r; int lat; bit early, st, to;
    do_write(BASE + 32'hC, 32'h0BADF00D, 4'hF, 1, 0, 5, r, lat, early, st, to);
    model_write(BASE + 32'hC, 32'h0BADF00D, 4'hF);
    tests_run++;
    if (to || !st || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL b_backpressure: stable=%0d bresp=%b timeout=%0d required 1 00 0", st, r, to);
    end
    do_read(BASE + 32'hC, 5, d, r, lat, st, to);
    tests_run++;
    if (to || !st || d !== 32'h0BADF00D || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL r_backpressure: stable=%0d rdata=%h rresp=%b required 1 0badf00d 00", st, d, r);
    end
  endtask

  task automatic test_concurrent_rw();
    logic [31:0] old, d; logic [1:0] r; int lat; bit st, to;
    old = model_mem[0];
    @(negedge aclk);
    bus.awaddr = BASE; bus.awvalid = 1'b1; bus.wdata = 32'h5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = BASE; bus.arvalid = 1'b1;
    tests_run++;
    if (bus.awready !== 1'b1 || bus.wready !== 1'b1 || bus.arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL concurrent_ready: aw/w/ar ready=%b%b%b required 111", bus.awready, bus.wready, bus.arready);
    end
    @(negedge aclk);
    bus_idle();
    model_write(BASE, 32'h5, 4'hF);
    tests_run++;
    if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1 || bus.rdata !== old || bus.rresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL concurrent_old_value: bvalid=%b rvalid=%b rdata=%h required 1 1 %h",
               bus.bvalid, bus.rvalid, bus.rdata, old);
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    do_read(BASE, 0, d, r, lat, st, to);
    tests_run++;
    if (to || d !== 32'h5) begin
      tests_failed++;
      $display("FAIL concurrent_new_value: rdata=%h required 00000005", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, got, exp_d; logic [3:0] s; logic [1:0] r, exp_r; int lat; bit early, st, to;
    for (int n = 0; n < 40; n++) begin
      a = BASE - 32'h8 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      exp_r = model_ok(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 r, lat, early, st, to);
        model_write(a, d, s);
        tests_run++;
        if (to || early || !st || r !== exp_r || lat != 1) begin
          tests_failed++;
          $display("FAIL rand_write[%0d] addr=%h: bresp=%b lat=%0d early=%0d stable=%0d required %b 1 0 1",
                   n, a, r, lat, early, st, exp_r);
        end
      end else begin
        exp_q.push_back(model_ok(a) ? model_mem[model_idx(a)] : 32'h0);
        do_read(a, $urandom_range(0, 2), got, r, lat, st, to);
        exp_d = exp_q.pop_front();
        tests_run++;
        if (to || !st || got !== exp_d || r !== exp_r || lat != 1) begin
          tests_failed++;
          $display("FAIL rand_read[%0d] addr=%h: rdata=%h rresp=%b lat=%0d required %h %b 1",
                   n, a, got, r, lat, exp_d, exp_r);
        end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] d; logic [1:0] r; int lat; bit st, to; bit stale;
    @(negedge aclk);
    bus.awaddr = BASE + 32'h4; bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = BASE + 32'h4; bus.arvalid = 1'b1;
    @(negedge aclk);
    bus.arvalid = 1'b0;
    tests_run++;
    if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL inflight_setup: bvalid=%b rvalid=%b required 1 1", bus.bvalid, bus.rvalid);
    end
    areset_n = 1'b0;
    @(negedge aclk);
    tests_run++;
    if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0 || bus.bresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL inflight_reset: bvalid=%b rvalid=%b rdata=%h bresp=%b required 0 0 0 00",
               bus.bvalid, bus.rvalid, bus.rdata, bus.bresp);
    end
    areset_n = 1'b1;
    model_clear();
    bus.bready = 1'b1; bus.rready = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge aclk);
      if (bus.bvalid || bus.rvalid) stale = 1;
    end
    bus.bready = 1'b0; bus.rready = 1'b0;
    tests_run++;
    if (stale) begin
      tests_failed++;
      $display("FAIL inflight_no_stale: stale response=1 required 0");
    end
    for (int i = 0; i < NREGS; i++) begin
      do_read(BASE + 32'(4 * i), 0, d, r, lat, st, to);
      tests_run++;
      if (to || d !== model_mem[i]) begin
        tests_failed++;
        $display("FAIL inflight_regs_cleared[%0d]: rdata=%h required %h", i, d, model_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle_aw_w();
    test_w_before_aw();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure();
    test_concurrent_rw();
    test_random();
    test_reset_in_flight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
